// File: rtl/spi_drv.sv
// spi_drv -- SPI master (mode 0) with a command/ready handshake.
//
// Shifts up to SPI_MAXLEN bits MSB-first on MOSI while capturing MISO.
// SCLK idles low; MISO is sampled on the clk edge that raises SCLK and
// MOSI advances on the clk edge that lowers it. SS_N is active low.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   sresetn      synchronous reset, active HIGH despite the name
//   start_cmd    command request level; n_clks/tx_data valid while high
//   spi_drv_rdy  1 = idle; falls on acceptance, rises on completion
//   n_clks       requested SCLK pulse count (clamped to SPI_MAXLEN)
//   tx_data      transmit word, first bit tx_data[n-1]
//   rx_miso      received word, updated only at completion or reset
//   SCLK/MOSI/MISO/SS_N  SPI bus
//
// Optional: define SPI_DRV_ASSERT_EN to compile simulation-only checks.
module spi_drv #(
  parameter int CLK_DIVIDE = 100,
  parameter int SPI_MAXLEN = 32
) (
  input  logic                          clk,
  input  logic                          sresetn,
  input  logic                          start_cmd,
  output logic                          spi_drv_rdy,
  input  logic [$clog2(SPI_MAXLEN):0]   n_clks,
  input  logic [SPI_MAXLEN-1:0]         tx_data,
  output logic [SPI_MAXLEN-1:0]         rx_miso,
  output logic                          SCLK,
  output logic                          MOSI,
  input  logic                          MISO,
  output logic                          SS_N
);

  localparam int H  = CLK_DIVIDE / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam int NW = $clog2(SPI_MAXLEN) + 1;

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, DONE} state_t;

  state_t                state_reg,   state_next;
  logic [CW-1:0]         cnt_reg,     cnt_next;
  logic [NW-1:0]         n_reg,       n_next;
  logic [NW-1:0]         nbit_reg,    nbit_next;   // HIGH phases completed
  logic [SPI_MAXLEN-1:0] tx_sh_reg,   tx_sh_next;  // current bit at the MSB
  logic [SPI_MAXLEN-1:0] rx_sh_reg,   rx_sh_next;
  logic [SPI_MAXLEN-1:0] rx_miso_reg, rx_miso_next;

  logic          phase_end;
  logic [NW-1:0] n_clamped;
  logic [NW-1:0] tx_shamt;
  logic          busy;

  assign phase_end = (cnt_reg == CW'(H - 1));
  assign n_clamped = (n_clks > NW'(SPI_MAXLEN)) ? NW'(SPI_MAXLEN) : n_clks;
  // Left-align the n transmitted bits so MOSI is always the MSB.
  assign tx_shamt  = NW'(SPI_MAXLEN) - n_clamped;
  assign busy      = (state_reg == LEAD) || (state_reg == HIGH) || (state_reg == LOW);

  always_ff @(posedge clk) begin
    if (sresetn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      n_reg       <= '0;
      nbit_reg    <= '0;
      tx_sh_reg   <= '0;
      rx_sh_reg   <= '0;
      rx_miso_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      n_reg       <= n_next;
      nbit_reg    <= nbit_next;
      tx_sh_reg   <= tx_sh_next;
      rx_sh_reg   <= rx_sh_next;
      rx_miso_reg <= rx_miso_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CW'(1);
    n_next       = n_reg;
    nbit_next    = nbit_reg;
    tx_sh_next   = tx_sh_reg;
    rx_sh_next   = rx_sh_reg;
    rx_miso_next = rx_miso_reg;

    case (state_reg)
      // DONE looks exactly like IDLE and also accepts, so a held start_cmd
      // sees rdy high for only the single completion cycle.
      IDLE, DONE: begin
        cnt_next = '0;
        if (start_cmd) begin
          state_next = LEAD;
          n_next     = n_clamped;
          nbit_next  = '0;
          tx_sh_next = tx_data << tx_shamt;
          rx_sh_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      LEAD: begin
        if (phase_end) begin
          cnt_next = '0;
          if (n_reg == '0) begin
            state_next   = DONE;
            rx_miso_next = '0;
          end else begin
            state_next = HIGH;
            rx_sh_next = {rx_sh_reg[SPI_MAXLEN-2:0], MISO};
          end
        end
      end
      HIGH: begin
        if (phase_end) begin
          cnt_next   = '0;
          state_next = LOW;
          nbit_next  = nbit_reg + NW'(1);
          // After the last bit MOSI keeps its value through the trailing half.
          if (nbit_reg + NW'(1) != n_reg)
            tx_sh_next = tx_sh_reg << 1;
        end
      end
      LOW: begin
        if (phase_end) begin
          cnt_next = '0;
          if (nbit_reg == n_reg) begin
            state_next   = DONE;
            rx_miso_next = rx_sh_reg;
          end else begin
            state_next = HIGH;
            rx_sh_next = {rx_sh_reg[SPI_MAXLEN-2:0], MISO};
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign spi_drv_rdy = !busy;
  assign SS_N        = !busy;
  assign SCLK        = (state_reg == HIGH);
  assign MOSI        = busy && tx_sh_reg[SPI_MAXLEN-1];
  assign rx_miso     = rx_miso_reg;

`ifdef SPI_DRV_ASSERT_EN
  a_clk_divide: assert property (@(posedge clk) (CLK_DIVIDE % 2 == 0) && (CLK_DIVIDE >= 4));
  a_ss_sclk:    assert property (@(posedge clk) disable iff (sresetn) SCLK |-> !SS_N);
  a_rdy_ss:     assert property (@(posedge clk) disable iff (sresetn) !SS_N |-> !spi_drv_rdy);

  always @(posedge clk) begin
    if (!sresetn && !busy && start_cmd && (n_clks > NW'(SPI_MAXLEN)))
      $error("spi_drv: n_clks=%0d exceeds SPI_MAXLEN=%0d, clamped", n_clks, SPI_MAXLEN);
  end
`else
`endif

endmodule

// File: tb/tb_spi_drv.sv
// Testbench for spi_drv: directed scenarios plus randomized commands, all
// checked every cycle against a timing/data model derived from the rules
// (phase arithmetic on cycles since acceptance, expected words by bit loop).
module tb_spi_drv;

  localparam int CLK_DIVIDE = 100;
  localparam int SPI_MAXLEN = 32;
  localparam int H          = CLK_DIVIDE / 2;
  localparam int NW         = $clog2(SPI_MAXLEN) + 1;

  logic          clk = 1'b0;
  logic          sresetn = 1'b1;
  logic          start_cmd = 1'b0;
  logic          spi_drv_rdy;
  logic [NW-1:0] n_clks = '0;
  logic [31:0]   tx_data = '0;
  logic [31:0]   rx_miso;
  logic          SCLK;
  logic          MOSI;
  logic          MISO;
  logic          SS_N;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Stimulus side-channel for the slave model
  bit          loop_i = 1'b0;
  logic [31:0] pat_i  = '0;

  // Behavioural model state
  bit          m_busy = 1'b0;
  int          m_u    = 0;
  int          m_n    = 0;
  logic [31:0] m_tx   = '0;
  logic [31:0] m_pat  = '0;
  logic [31:0] m_rx   = '0;
  bit          m_loop = 1'b0;
  logic        miso_drv = 1'b0;

  // Transaction observers
  int          pulse_cnt = 0;
  logic [31:0] mosi_seq  = '0;
  logic        prev_sclk = 1'b0;
  logic        prev_rdy  = 1'b1;

  assign MISO = m_loop ? MOSI : miso_drv;

  always #5 clk = ~clk;

  spi_drv #(.CLK_DIVIDE(CLK_DIVIDE), .SPI_MAXLEN(SPI_MAXLEN)) dut (
    .clk(clk), .sresetn(sresetn), .start_cmd(start_cmd), .spi_drv_rdy(spi_drv_rdy),
    .n_clks(n_clks), .tx_data(tx_data), .rx_miso(rx_miso), .SCLK(SCLK),
    .MOSI(MOSI), .MISO(MISO), .SS_N(SS_N)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_rx(input int n, input logic [31:0] tx,
                                            input logic [31:0] pat, input bit loop);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = loop ? tx[i] : pat[i];
    return r;
  endfunction

  // Model: a transaction occupies (2n+1)H cycles after acceptance.
  always @(posedge clk) begin
    if (sresetn) begin
      m_busy = 1'b0;
      m_rx   = '0;
    end else if (!m_busy) begin
      if (start_cmd) begin
        m_n    = (int'(n_clks) > SPI_MAXLEN) ? SPI_MAXLEN : int'(n_clks);
        m_tx   = tx_data;
        m_pat  = pat_i;
        m_loop = loop_i;
        m_u    = 0;
        m_busy = 1'b1;
      end
    end else begin
      m_u++;
      if (m_u == (2 * m_n + 1) * H) begin
        m_busy = 1'b0;
        m_rx   = expect_rx(m_n, m_tx, m_pat, m_loop);
      end
    end
  end

  // Compare process: every cycle, on the falling clk edge.
  always @(negedge clk) begin
    logic e_rdy, e_ss, e_sclk, e_mosi;
    int   b;
    e_rdy = 1'b1; e_ss = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
    if (m_busy) begin
      e_rdy  = 1'b0;
      e_ss   = 1'b0;
      e_sclk = (m_u >= H) && (((m_u - H) % (2 * H)) < H);
      if (m_n > 0) begin
        b = m_u / (2 * H);
        if (b > m_n - 1) b = m_n - 1;
        e_mosi = m_tx[m_n - 1 - b];
      end
    end
    if (chk_en) begin
      chk("rdy", spi_drv_rdy, e_rdy);
      chk("ss_n", SS_N, e_ss);
      chk("sclk", SCLK, e_sclk);
      if (!m_busy || m_n > 0) chk("mosi", MOSI, e_mosi);
      chk("rx_miso", rx_miso, m_rx);
      if (prev_rdy === 1'b1 && spi_drv_rdy === 1'b0) begin
        pulse_cnt = 0;
        mosi_seq  = '0;
      end
      if (SCLK === 1'b1 && prev_sclk === 1'b0) begin
        pulse_cnt++;
        mosi_seq = {mosi_seq[30:0], MOSI};
      end
    end
    prev_sclk = SCLK;
    prev_rdy  = spi_drv_rdy;
    // Slave model presents bit k for the whole k-th SCLK period.
    if (m_busy && m_n > 0) begin
      b = m_u / (2 * H);
      if (b > m_n - 1) b = m_n - 1;
      miso_drv = m_pat[m_n - 1 - b];
    end else begin
      miso_drv = 1'b0;
    end
  end

  task automatic issue(input int nc, input logic [31:0] tx, input bit loop, input logic [31:0] pat);
    n_clks    = NW'(nc);
    tx_data   = tx;
    loop_i    = loop;
    pat_i     = pat;
    start_cmd = 1'b1;
  endtask

  task automatic wait_fall();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (spi_drv_rdy === 1'b0) break;
    end
    chk("accept", spi_drv_rdy, 1'b0);
  endtask

  task automatic wait_rise(output int low);
    low = 1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (spi_drv_rdy === 1'b1) break;
      low++;
    end
    chk("complete", spi_drv_rdy, 1'b1);
  endtask

  task automatic run_cmd(input int nc, input logic [31:0] tx, input bit loop,
                         input logic [31:0] pat, output int low);
    issue(nc, tx, loop, pat);
    wait_fall();
    start_cmd = 1'b0;
    n_clks    = NW'($urandom);
    tx_data   = $urandom;
    wait_rise(low);
  endtask

  initial begin
    int low, nc, en;
    logic [31:0] tx, pat;
    bit lp;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", spi_drv_rdy, 1'b1);
    chk("reset_ss_n", SS_N, 1'b1);
    chk("reset_sclk", SCLK, 1'b0);
    chk("reset_mosi", MOSI, 1'b0);
    chk("reset_rx", rx_miso, 32'h0);
    chk_en  = 1'b1;
    sresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Loopback, full length
    run_cmd(32, 32'hC128ABE9, 1'b1, 32'h0, low);
    chk("loop32_low", low, 3250);
    chk("loop32_rx", rx_miso, 32'hC128ABE9);
    chk("loop32_pulses", pulse_cnt, 32);
    chk("loop32_mosi_seq", mosi_seq, 32'hC128ABE9);

    // Back-to-back with start_cmd held high
    repeat (2) @(posedge clk);
    #1;
    issue(32, 32'hB991FE65, 1'b1, 32'h0);
    wait_fall();
    tx_data = 32'hE08657BB;
    wait_rise(low);
    chk("b2b_first_low", low, 3250);
    chk("b2b_first_rx", rx_miso, 32'hB991FE65);
    @(posedge clk); #1;
    chk("b2b_rdy_one_cycle", spi_drv_rdy, 1'b0);
    start_cmd = 1'b0;
    tx_data   = $urandom;
    repeat (1000) @(posedge clk);
    #1;
    chk("b2b_rx_hold", rx_miso, 32'hB991FE65);
    wait_rise(low);
    chk("b2b_second_rx", rx_miso, 32'hE08657BB);

    // n=0 held, followed directly by MISO-tied-1 n=8 command
    repeat (2) @(posedge clk);
    #1;
    issue(0, 32'hFFFF_FFFF, 1'b1, 32'h0);
    wait_fall();
    n_clks  = NW'(8);
    tx_data = 32'h000000A5;
    loop_i  = 1'b0;
    pat_i   = 32'hFFFF_FFFF;
    wait_rise(low);
    chk("n0_low", low, 50);
    chk("n0_rx", rx_miso, 32'h0);
    chk("n0_pulses", pulse_cnt, 0);
    @(posedge clk); #1;
    chk("n0_next_accept", spi_drv_rdy, 1'b0);
    start_cmd = 1'b0;
    wait_rise(low);
    chk("a5_low", low, 850);
    chk("a5_rx", rx_miso, 32'h000000FF);
    chk("a5_pulses", pulse_cnt, 8);
    chk("a5_mosi_seq", mosi_seq & 32'hFF, 32'hA5);

    // Clamp n_clks=36 -> 32
    run_cmd(36, 32'hC128ABE9, 1'b1, 32'h0, low);
    chk("clamp_low", low, 3250);
    chk("clamp_rx", rx_miso, 32'hC128ABE9);
    chk("clamp_pulses", pulse_cnt, 32);

    // Reset mid-transfer after 10 SCLK pulses
    issue(32, $urandom, 1'b1, 32'h0);
    wait_fall();
    start_cmd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (pulse_cnt >= 10) break;
    end
    chk("rst_pulses", pulse_cnt, 10);
    sresetn   = 1'b1;
    start_cmd = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", spi_drv_rdy, 1'b1);
    chk("rst_ss_n", SS_N, 1'b1);
    chk("rst_sclk", SCLK, 1'b0);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_rx", rx_miso, 32'h0);
    @(posedge clk); #1;
    chk("rst_ignore_cmd", spi_drv_rdy, 1'b1);
    sresetn   = 1'b0;
    start_cmd = 1'b0;
    @(posedge clk); #1;
    tx  = $urandom;
    pat = $urandom;
    run_cmd(20, tx, 1'b0, pat, low);
    chk("post_rst_low", low, 2050);
    chk("post_rst_rx", rx_miso, expect_rx(20, tx, pat, 1'b0));

    // Randomized commands
    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      nc  = $urandom_range(0, 40);
      tx  = $urandom;
      pat = $urandom;
      lp  = 1'($urandom_range(0, 1));
      en  = (nc > SPI_MAXLEN) ? SPI_MAXLEN : nc;
      run_cmd(nc, tx, lp, pat, low);
      chk("rand_low", low, (2 * en + 1) * H);
      chk("rand_rx", rx_miso, expect_rx(en, tx, pat, lp));
      chk("rand_pulses", pulse_cnt, en);
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_drv.md
# spi_drv

SPI master driver with a command/ready handshake toward a host. It clocks out up to SPI_MAXLEN bits MSB-first on MOSI while capturing MISO, generating SCLK (mode 0: idle low, sample rising, shift falling) and an active-low SS_N. It sits between a host register/controller block and the external SPI bus.

## Interface
- CLK_DIVIDE, 100, clk cycles per SCLK period; even and >= 4; half period H = CLK_DIVIDE/2.
- SPI_MAXLEN, 32, maximum bits per transaction; width of tx_data/rx_miso.
- clk  in  1  system clock; all logic on its rising edge.
- sresetn  in  1  synchronous, active-high reset (name kept per codebase; asserted = 1).
- start_cmd  in  1  command request (level); n_clks/tx_data valid while high.
- spi_drv_rdy  out  1  1 = idle/ready; 1->0 acknowledges a command; 0->1 signals completion.
- n_clks  in  $clog2(SPI_MAXLEN)+1  number of SCLK pulses requested.
- tx_data  in  SPI_MAXLEN  data to send; first bit tx_data[n-1], last tx_data[0].
- rx_miso  out  SPI_MAXLEN  received data; rx_miso[n-1] first bit, rx_miso[0] last.
- SCLK  out  1  SPI clock, idle 0.
- MOSI  out  1  master data out.
- MISO  in  1  slave data in.
- SS_N  out  1  slave select, active low.

## Operation
- States: IDLE, LEAD, HIGH, LOW, DONE.
- IDLE: spi_drv_rdy=1, SS_N=1, SCLK=0, MOSI=0. If start_cmd=1 at a clk edge: latch n = min(n_clks, SPI_MAXLEN) and tx_data; go LEAD.
- LEAD (H cycles): spi_drv_rdy=0, SS_N=0, SCLK=0, MOSI=tx[n-1].
- HIGH (H cycles): SCLK=1; MISO sampled into internal shift register on the clk edge that raises SCLK.
- LOW (H cycles): SCLK=0; on the clk edge that lowers SCLK, MOSI advances to the next bit (after the last bit, MOSI holds it). After n HIGH phases, the final LOW phase is the trailing half-period.
- DONE (1-cycle transition to IDLE): rx_miso <= captured bits in [n-1:0], upper bits 0; SS_N=1; spi_drv_rdy=1, all in the same cycle.
- rx_miso changes only at completion or reset; stable through the next transaction until its completion.
- n=0: no SCLK pulses; SS_N low and rdy low for H cycles; rx_miso <= 0.
- n_clks > SPI_MAXLEN: clamped to SPI_MAXLEN.
- start_cmd while busy: ignored. start_cmd still high on return to IDLE: new command accepted after rdy has been 1 for exactly one cycle.
- tx_data/n_clks sampled only at acceptance; later changes have no effect.

## Timing
- Acceptance edge T; spi_drv_rdy falls and SS_N falls at T+1.
- SCLK rising edge k (k=0..n-1) at T+1+H+2kH; falling at T+1+2(k+1)H.
- Completion (rdy=1, SS_N=1, rx_miso valid) at T+1+(2n+1)H; rdy low for exactly (2n+1)H cycles.
- SCLK duty 50%, period CLK_DIVIDE cycles.
- Reset (sresetn=1), including mid-transaction: next edge enters IDLE; spi_drv_rdy=1, SS_N=1, SCLK=0, MOSI=0, rx_miso=0, internal counters/shift registers cleared. Commands ignored while sresetn=1.

## Configuration
- SPI_DRV_ASSERT_EN: when defined, simulation-only assertions compiled in: CLK_DIVIDE even and >= 4; SS_N low whenever SCLK=1; spi_drv_rdy=0 whenever SS_N=0; $error on n_clks > SPI_MAXLEN at acceptance (clamping still applied). When undefined, no assertion code; functional behaviour identical.

## Test plan
- MOSI looped to MISO, n=32, tx 0xC128ABE9 -> rx_miso 0xC128ABE9 at rdy rise; rdy low 3250 cycles (CLK_DIVIDE=100); 32 SCLK pulses.
- Loopback back-to-back 0xB991FE65 then 0xE08657BB -> each received exactly; rx_miso holds 0xB991FE65 through second transaction until its completion.
- MISO tied 1, n=8, tx 0xA5 -> MOSI sequence 1,0,1,0,0,1,0,1 on rising edges; rx_miso 0x000000FF.
- Loopback n_clks=36 with tx 0xC128ABE9 -> treated as 32; rx 0xC128ABE9; 32 pulses (assertion fires if SPI_DRV_ASSERT_EN).
- Reset asserted mid-transfer (after 10 SCLK pulses) -> next cycle rdy=1, SS_N=1, SCLK=0, rx_miso=0; subsequent command completes normally.
- n_clks=0 with start_cmd held high -> rdy low 50 cycles, no SCLK, rx_miso 0; rdy high one cycle, then next command accepted.
